// File: rtl/core_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pipe_pkg
// Description : Shared defaults, occupancy state encoding and the per-lane
//               writeback record used by the MEM/WB pipeline slice.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pipe_pkg;

    // Default configuration of the MEM/WB slice.
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;
    localparam int DEF_LANES  = 2;

    // Occupancy states. The encoding equals the number of held bundles, so
    // the state register drives the occupancy output directly.
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // Per-lane writeback record at the default widths.
    typedef struct packed {
        logic                  regwrite;
        logic [DEF_REG_AW-1:0] dest_reg;
        logic [DEF_DATA_W-1:0] data;
    } wb_lane_t;

endpackage : core_pipe_pkg
`default_nettype wire

// File: rtl/core_mem_wb_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : core_mem_wb_pipe_if
// Description : MEM->WB bundle handshake. The slave modport is the pipeline
//               register; the master modport is the surrounding core / bench.
//               in_*      : bundle offered by MEM (valid/ready handshake)
//               flush     : discard held and offered bundles
//               wb_*      : head bundle presented to WB (valid/ready)
//               occupancy : number of held bundles (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
interface core_mem_wb_pipe_if
    import core_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int LANES  = DEF_LANES
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES-1:0]          in_regwrite;
    logic [LANES-1:0]          in_memtoreg;
    logic [LANES*DATA_W-1:0]   in_aluresult;
    logic [LANES*DATA_W-1:0]   in_memdata;
    logic [LANES*REG_AW-1:0]   in_dest_reg;
    logic                      flush;
    logic                      wb_valid;
    logic                      wb_ready;
    logic [LANES-1:0]          wb_regwrite;
    logic [LANES*REG_AW-1:0]   wb_dest_reg;
    logic [LANES*DATA_W-1:0]   wb_data;
    logic [1:0]                occupancy;

    modport slave (
        input  in_valid, in_regwrite, in_memtoreg, in_aluresult, in_memdata,
               in_dest_reg, flush, wb_ready,
        output in_ready, wb_valid, wb_regwrite, wb_dest_reg, wb_data, occupancy
    );

    modport master (
        output in_valid, in_regwrite, in_memtoreg, in_aluresult, in_memdata,
               in_dest_reg, flush, wb_ready,
        input  in_ready, wb_valid, wb_regwrite, wb_dest_reg, wb_data, occupancy
    );

endinterface : core_mem_wb_pipe_if
`default_nettype wire

// File: rtl/core_wb_lane_sel.sv
`default_nettype none
// ============================================================================
// Module      : core_wb_lane_sel
// Description : Per-lane capture logic: selects memory data or ALU result and
//               suppresses the register write when the destination is r0.
//               i_regwrite/i_memtoreg/i_aluresult/i_memdata/i_dest_reg : lane in
//               o_regwrite/o_dest_reg/o_data                           : lane out
// Revision    : 1.0 - initial release
// ============================================================================
module core_wb_lane_sel #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  wire logic              i_regwrite,
    input  wire logic              i_memtoreg,
    input  wire logic [DATA_W-1:0] i_aluresult,
    input  wire logic [DATA_W-1:0] i_memdata,
    input  wire logic [REG_AW-1:0] i_dest_reg,
    output logic                   o_regwrite,
    output logic [REG_AW-1:0]      o_dest_reg,
    output logic [DATA_W-1:0]      o_data
);

    // r0 is hardwired to zero, so a write to it is never committed.
    assign o_regwrite = i_regwrite && (i_dest_reg != '0);
    assign o_dest_reg = i_dest_reg;
    assign o_data     = i_memtoreg ? i_memdata : i_aluresult;

endmodule : core_wb_lane_sel
`default_nettype wire

// File: rtl/core_mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : core_mem_wb_pipe
// Description : MEM/WB pipeline register for a multi-lane core, built as a
//               two-entry in-order buffer (head + skid). Writeback data is
//               selected at capture time, so WB sees final values.
//               clk, rst : clock, synchronous active-high reset
//               bus      : core_mem_wb_pipe_if slave modport (MEM in, WB out)
// Revision    : 1.0 - initial release
// ============================================================================
module core_mem_wb_pipe
    import core_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int LANES  = DEF_LANES
) (
    input  wire logic          clk,
    input  wire logic          rst,
    core_mem_wb_pipe_if.slave  bus
);

    typedef struct packed {
        logic [LANES-1:0]        regwrite;
        logic [LANES*REG_AW-1:0] dest_reg;
        logic [LANES*DATA_W-1:0] data;
    } bundle_t;

    logic [1:0] r_occ;
    bundle_t    r_head;
    bundle_t    r_skid;
    bundle_t    w_cap;
    logic       w_in_ready;
    logic       w_wb_valid;
    logic       w_accept;
    logic       w_pop;

    // ------------------------------------------------------------------------
    // Per-lane capture: mux and r0 gating ahead of the storage registers.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        core_wb_lane_sel #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW)
        ) u_lane_sel (
            .i_regwrite  (bus.in_regwrite[gi]),
            .i_memtoreg  (bus.in_memtoreg[gi]),
            .i_aluresult (bus.in_aluresult[gi*DATA_W +: DATA_W]),
            .i_memdata   (bus.in_memdata[gi*DATA_W +: DATA_W]),
            .i_dest_reg  (bus.in_dest_reg[gi*REG_AW +: REG_AW]),
            .o_regwrite  (w_cap.regwrite[gi]),
            .o_dest_reg  (w_cap.dest_reg[gi*REG_AW +: REG_AW]),
            .o_data      (w_cap.data[gi*DATA_W +: DATA_W])
        );
    end

    // Ready and valid decode only the occupancy register, so there is no
    // combinational path from wb_ready back to in_ready.
    assign w_in_ready = (r_occ != OCC_FULL);
    assign w_wb_valid = (r_occ != OCC_EMPTY);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_pop      = w_wb_valid && bus.wb_ready;

    // ------------------------------------------------------------------------
    // Occupancy state machine and entry storage.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ  <= OCC_EMPTY;
            r_head <= '0;
            r_skid <= '0;
        end else if (bus.flush) begin
            // Held entries are invalidated; the offered bundle is not captured.
            r_occ <= OCC_EMPTY;
        end else begin
            case (r_occ)
                OCC_EMPTY: begin
                    if (w_accept) begin
                        r_head <= w_cap;
                        r_occ  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (w_accept && w_pop) begin
                        // Old head leaves while the new bundle takes its place.
                        r_head <= w_cap;
                    end else if (w_accept) begin
                        r_skid <= w_cap;
                        r_occ  <= OCC_FULL;
                    end else if (w_pop) begin
                        r_occ  <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // in_ready is low here, so only a pop can occur.
                    if (w_pop) begin
                        r_head <= r_skid;
                        r_occ  <= OCC_ONE;
                    end
                end
                default: begin
                    r_occ <= OCC_EMPTY;
                end
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.wb_valid    = w_wb_valid;
    assign bus.wb_regwrite = w_wb_valid ? r_head.regwrite : '0;
    assign bus.wb_dest_reg = r_head.dest_reg;
    assign bus.wb_data     = r_head.data;
    assign bus.occupancy   = r_occ;

endmodule : core_mem_wb_pipe
`default_nettype wire

// File: tb/tb_core_mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_mem_wb_pipe
// Description : Directed self-checking bench for core_mem_wb_pipe (LANES=2,
//               DATA_W=32, REG_AW=5) with hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_mem_wb_pipe;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int LANES  = 2;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    core_mem_wb_pipe_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .LANES(LANES)) bus ();

    core_mem_wb_pipe #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .LANES  (LANES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a bundle with ALU data in both lanes and regwrite on both lanes.
    task automatic offer(input logic [31:0] alu1, input logic [31:0] alu0,
                         input logic [4:0] rd1, input logic [4:0] rd0);
        bus.in_valid     = 1'b1;
        bus.in_regwrite  = 2'b11;
        bus.in_memtoreg  = 2'b00;
        bus.in_aluresult = {alu1, alu0};
        bus.in_memdata   = 64'hDEAD_DEAD_DEAD_DEAD;
        bus.in_dest_reg  = {rd1, rd0};
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst              = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_regwrite  = '0;
        bus.in_memtoreg  = '0;
        bus.in_aluresult = '0;
        bus.in_memdata   = '0;
        bus.in_dest_reg  = '0;
        bus.flush        = 1'b0;
        bus.wb_ready     = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        rst = 1'b0;
        chk("rst_occ",      64'(bus.occupancy),   64'd0);
        chk("rst_wb_valid", 64'(bus.wb_valid),    64'd0);
        chk("rst_wb_rw",    64'(bus.wb_regwrite), 64'd0);
        chk("rst_wb_data",  64'(bus.wb_data),     64'd0);
        chk("rst_wb_dest",  64'(bus.wb_dest_reg), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready),    64'd1);

        // ---------------- single bundle, mixed mux ----------------
        bus.in_valid     = 1'b1;
        bus.in_regwrite  = 2'b11;
        bus.in_memtoreg  = 2'b10;
        bus.in_aluresult = {32'h99, 32'h11};
        bus.in_memdata   = {32'hAB, 32'h55};
        bus.in_dest_reg  = {5'd7, 5'd3};
        bus.wb_ready     = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("single_valid", 64'(bus.wb_valid),    64'd1);
        chk("single_data",  64'(bus.wb_data),     64'h0000_00AB_0000_0011);
        chk("single_rw",    64'(bus.wb_regwrite), 64'd3);
        chk("single_dest",  64'(bus.wb_dest_reg), 64'h0E3);
        chk("single_occ",   64'(bus.occupancy),   64'd1);
        step();
        chk("single_drain_occ", 64'(bus.occupancy),   64'd0);
        chk("single_drain_rw",  64'(bus.wb_regwrite), 64'd0);

        // ---------------- rd == 0 gating ----------------
        bus.wb_ready = 1'b0;
        offer(32'h22, 32'h33, 5'd4, 5'd0);
        step();
        bus.in_valid = 1'b0;
        chk("rd0_rw",   64'(bus.wb_regwrite), 64'd2);
        chk("rd0_data", 64'(bus.wb_data),     64'h0000_0022_0000_0033);
        bus.wb_ready = 1'b1;
        step();
        chk("rd0_drain_occ", 64'(bus.occupancy), 64'd0);

        // ---------------- backpressure ----------------
        bus.wb_ready = 1'b0;
        offer(32'hA1, 32'hA0, 5'd1, 5'd2);
        step();
        chk("bp_occ_a", 64'(bus.occupancy), 64'd1);
        offer(32'hB1, 32'hB0, 5'd5, 5'd6);
        step();
        chk("bp_occ_ab",   64'(bus.occupancy), 64'd2);
        chk("bp_in_ready", 64'(bus.in_ready),  64'd0);
        chk("bp_head_a",   64'(bus.wb_data),   64'h0000_00A1_0000_00A0);
        offer(32'hC1, 32'hC0, 5'd8, 5'd9);
        step();
        chk("bp_third_occ",  64'(bus.occupancy), 64'd2);
        chk("bp_hold_a",     64'(bus.wb_data),   64'h0000_00A1_0000_00A0);
        chk("bp_hold_a_dst", 64'(bus.wb_dest_reg), 64'h022);
        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b1;
        step();
        chk("bp_pop_b",     64'(bus.wb_data),     64'h0000_00B1_0000_00B0);
        chk("bp_pop_b_dst", 64'(bus.wb_dest_reg), 64'h0A6);
        chk("bp_pop_occ",   64'(bus.occupancy),   64'd1);
        step();
        chk("bp_empty_occ",   64'(bus.occupancy), 64'd0);
        chk("bp_empty_valid", 64'(bus.wb_valid),  64'd0);

        // ---------------- flush with full buffer and offer ----------------
        bus.wb_ready = 1'b0;
        offer(32'hA1, 32'hA0, 5'd1, 5'd2);
        step();
        offer(32'hB1, 32'hB0, 5'd5, 5'd6);
        step();
        chk("fl_pre_occ", 64'(bus.occupancy), 64'd2);
        offer(32'hC1, 32'hC0, 5'd8, 5'd9);
        bus.flush = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_occ",      64'(bus.occupancy),   64'd0);
        chk("fl_valid",    64'(bus.wb_valid),    64'd0);
        chk("fl_rw",       64'(bus.wb_regwrite), 64'd0);
        chk("fl_in_ready", 64'(bus.in_ready),    64'd1);
        step();
        chk("fl_no_c_occ",   64'(bus.occupancy), 64'd0);
        chk("fl_no_c_valid", 64'(bus.wb_valid),  64'd0);

        // ---------------- streaming ----------------
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            offer(32'(i + 32'h100), 32'(i + 32'h40), 5'(i + 9), 5'(i + 1));
            step();
            chk("st_valid", 64'(bus.wb_valid),    64'd1);
            chk("st_data",  64'(bus.wb_data),     {32'(i + 32'h100), 32'(i + 32'h40)});
            chk("st_dest",  64'(bus.wb_dest_reg), 64'({5'(i + 9), 5'(i + 1)}));
            chk("st_occ",   64'(bus.occupancy),   64'd1);
            chk("st_ready", 64'(bus.in_ready),    64'd1);
        end
        bus.in_valid = 1'b0;
        step();
        chk("st_end_occ", 64'(bus.occupancy), 64'd0);

        // ---------------- reset with full buffer ----------------
        bus.wb_ready = 1'b0;
        offer(32'h71, 32'h70, 5'd3, 5'd4);
        step();
        offer(32'h81, 32'h80, 5'd5, 5'd6);
        step();
        chk("rf_pre_occ", 64'(bus.occupancy), 64'd2);
        rst          = 1'b1;
        bus.flush    = 1'b1;
        bus.wb_ready = 1'b1;
        offer(32'h91, 32'h90, 5'd7, 5'd8);
        step();
        rst          = 1'b0;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("rf_occ",      64'(bus.occupancy),   64'd0);
        chk("rf_valid",    64'(bus.wb_valid),    64'd0);
        chk("rf_rw",       64'(bus.wb_regwrite), 64'd0);
        chk("rf_data",     64'(bus.wb_data),     64'd0);
        chk("rf_dest",     64'(bus.wb_dest_reg), 64'd0);
        chk("rf_in_ready", 64'(bus.in_ready),    64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_core_mem_wb_pipe
`default_nettype wire
